// File: rtl/hero_palette_arbiter.sv
// Round-robin shared palette lookup for up to eight sprite renderers with a registered RGB response.
// Optional chroma-key flag on index 0 enabled by defining PALETTE_CHROMA_KEY_EN.
module hero_palette_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*IDX_W-1:0] req_index,
  output logic [N_REQ-1:0]       gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2:0]             rsp_id,
  output logic [3:0]             rsp_red,
  output logic [3:0]             rsp_green,
  output logic [3:0]             rsp_blue,
  output logic                   rsp_transparent
);

  logic [2:0]       ptr_q, ptr_d;
  logic             can_issue;
  logic             found;
  logic [2:0]       win_id;
  logic [3:0]       cand;
  logic [3:0]       ptr_inc;
  logic [7:0]       req_ext;
  logic [7:0]       gnt_ext;
  logic [IDX_W-1:0] idx_arr [8];
  logic [IDX_W-1:0] win_idx;
  logic [11:0]      win_rgb;

  assign can_issue = !rsp_valid || rsp_ready;

  // Widen to eight lanes so indexing by a 3-bit id is legal for any N_REQ.
  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
    for (int unsigned i = 0; i < 8; i++) idx_arr[i] = '0;
    for (int unsigned i = 0; i < N_REQ; i++) idx_arr[i] = req_index[i*IDX_W +: IDX_W];
  end

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    if (can_issue) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = {1'b0, ptr_q} + 4'(k);
        if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
        if (!found && req_ext[cand[2:0]]) begin
          found  = 1'b1;
          win_id = cand[2:0];
        end
      end
    end
  end

  always_comb begin
    gnt_ext = '0;
    if (found) gnt_ext[win_id] = 1'b1;
    gnt = gnt_ext[N_REQ-1:0];
  end

  always_comb begin
    ptr_inc = {1'b0, win_id} + 4'd1;
    ptr_d   = ptr_q;
    if (found) ptr_d = (ptr_inc == 4'(N_REQ)) ? 3'd0 : ptr_inc[2:0];
  end

  assign win_idx = idx_arr[win_id];

  always_comb begin
    win_rgb = 12'h000;
    case (win_idx)
      3'd0: win_rgb = 12'h0E1;
      3'd1: win_rgb = 12'h04E;
      3'd2: win_rgb = 12'h000;
      3'd3: win_rgb = 12'hECA;
      3'd4: win_rgb = 12'hE30;
      3'd5: win_rgb = 12'h610;
      3'd6: win_rgb = 12'h776;
      3'd7: win_rgb = 12'h080;
      default: win_rgb = 12'h000;
    endcase
  end

  // No grant is possible while stalled, so the data only moves on issue.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_red   <= '0;
      rsp_green <= '0;
      rsp_blue  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (found) begin
        rsp_valid <= 1'b1;
        rsp_id    <= win_id;
        {rsp_red, rsp_green, rsp_blue} <= win_rgb;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef PALETTE_CHROMA_KEY_EN
  logic transp_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      transp_q <= 1'b0;
    end else if (found) begin
      transp_q <= (win_idx == '0);
    end
  end

  assign rsp_transparent = transp_q;
`else
  assign rsp_transparent = 1'b0;
`endif

endmodule

// File: tb/tb_hero_palette_arbiter.sv
// Directed self-checking bench for hero_palette_arbiter (default N_REQ=4).
module tb_hero_palette_arbiter;

  logic        Clk;
  logic        Reset;
  logic [3:0]  req;
  logic [11:0] req_index;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_id;
  logic [3:0]  rsp_red, rsp_green, rsp_blue;
  logic        rsp_transparent;

  int checks = 0;
  int errors = 0;

`ifdef PALETTE_CHROMA_KEY_EN
  localparam bit ExpChroma = 1'b1;
`else
  localparam bit ExpChroma = 1'b0;
`endif

  hero_palette_arbiter dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .req             (req),
    .req_index       (req_index),
    .gnt             (gnt),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_red         (rsp_red),
    .rsp_green       (rsp_green),
    .rsp_blue        (rsp_blue),
    .rsp_transparent (rsp_transparent)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  wire [11:0] rgb = {rsp_red, rsp_green, rsp_blue};

  // Leaves the bench just after a falling edge with Reset released.
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; req = '0; rsp_ready = 1'b1; req_index = '0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1; req = '0; rsp_ready = 1'b1; req_index = '0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rgb !== 12'h000 || rsp_transparent !== 1'b0
        || gnt !== 4'b0000)
      begin errors++; $display("FAIL reset_state: valid=%b id=%0d rgb=%h t=%b gnt=%b, want all 0",
        rsp_valid, rsp_id, rgb, rsp_transparent, gnt); end
    @(negedge Clk);
    Reset = 1'b0; req = 4'b0001; req_index = 12'd4;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
    @(posedge Clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rgb !== 12'hE30)
      begin errors++; $display("FAIL reset_first_rsp: valid=%b id=%0d rgb=%h want 1 0 e30",
        rsp_valid, rsp_id, rgb); end
    @(negedge Clk);
    req = '0;
    @(posedge Clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain: valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_rgb [4];
    logic [3:0]  exp_g;
    exp_rgb = '{12'h04E, 12'hECA, 12'h610, 12'h080};
    do_reset();
    req = 4'b1111; req_index = {3'd7, 3'd5, 3'd3, 3'd1};
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      #1;
      checks++;
      if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, exp_g); end
      @(posedge Clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'(c % 4) || rgb !== exp_rgb[c % 4])
        begin errors++; $display("FAIL rr_rsp[%0d]: valid=%b id=%0d rgb=%h want 1 %0d %h",
          c, rsp_valid, rsp_id, rgb, c % 4, exp_rgb[c % 4]); end
      @(negedge Clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b1111; req_index = {3'd7, 3'd5, 3'd3, 3'd1};
    repeat (3) begin @(posedge Clk); @(negedge Clk); end
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt[%0d]: got %b want 0000", c, gnt); end
      @(posedge Clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rgb !== 12'h610)
        begin errors++; $display("FAIL bp_hold[%0d]: valid=%b id=%0d rgb=%h want 1 2 610",
          c, rsp_valid, rsp_id, rgb); end
      @(negedge Clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL bp_resume_gnt: got %b want 1000", gnt); end
    @(posedge Clk); #1;
    checks++;
    if (rsp_id !== 3'd3 || rgb !== 12'h080)
      begin errors++; $display("FAIL bp_resume_rsp: id=%0d rgb=%h want 3 080", rsp_id, rgb); end
    @(negedge Clk);
  endtask

  task automatic test_skip_idle();
    do_reset();
    req = 4'b0001; req_index = {3'd6, 3'd0, 3'd0, 3'd2};
    @(posedge Clk); @(negedge Clk);
    req = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL skip_gnt3: got %b want 1000", gnt); end
    @(posedge Clk); #1;
    checks++;
    if (rsp_id !== 3'd3 || rgb !== 12'h776)
      begin errors++; $display("FAIL skip_rsp3: id=%0d rgb=%h want 3 776", rsp_id, rgb); end
    @(negedge Clk); #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL skip_gnt0: got %b want 0001", gnt); end
    @(posedge Clk); #1;
    checks++;
    if (rsp_id !== 3'd0 || rgb !== 12'h000)
      begin errors++; $display("FAIL skip_rsp0: id=%0d rgb=%h want 0 000", rsp_id, rgb); end
    @(negedge Clk);
  endtask

  task automatic test_chroma();
    do_reset();
    req = 4'b0010; req_index = {3'd5, 3'd5, 3'd0, 3'd5};
    #1;
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL chroma_gnt: got %b want 0010", gnt); end
    @(posedge Clk); #1;
    checks++;
    if (rsp_id !== 3'd1 || rgb !== 12'h0E1 || rsp_transparent !== ExpChroma)
      begin errors++; $display("FAIL chroma_rsp: id=%0d rgb=%h t=%b want 1 0e1 %b",
        rsp_id, rgb, rsp_transparent, ExpChroma); end
    @(negedge Clk);
    req = 4'b0001; req_index = {3'd5, 3'd5, 3'd0, 3'd3};
    @(posedge Clk); #1;
    checks++;
    if (rsp_transparent !== 1'b0 || rgb !== 12'hECA)
      begin errors++; $display("FAIL chroma_clear: t=%b rgb=%h want 0 eca", rsp_transparent, rgb); end
    @(negedge Clk);
    req = '0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    req = 4'b0001; req_index = 12'd4; rsp_ready = 1'b0;
    @(posedge Clk); @(negedge Clk);
    req = '0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rgb !== 12'h000)
      begin errors++; $display("FAIL stall_reset: valid=%b id=%0d rgb=%h want 0 0 000",
        rsp_valid, rsp_id, rgb); end
    @(negedge Clk);
    Reset = 1'b0; req = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_ptr: gnt=%b want 0001", gnt); end
    @(negedge Clk);
    req = '0; rsp_ready = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; req = '0; req_index = '0; rsp_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_skip_idle();
    test_chroma();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
